div_ctrl: RTL

- Sequencing controller for the RV32M divide path behind the execute stage.
- Accepts a DIV/DIVU/REM/REMU request from ex and runs a 32-iteration restoring shift-subtract sequence.
- Raises a pipeline stall request while busy, and presents the 32-bit result with a ready flag.
- Sits beside ex; its stall output feeds the pipeline control block.

---
 rtl/div_ctrl_pkg.sv | 31 +++
 rtl/div_step.sv | 28 ++
 rtl/div_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the RV32M divide path: op and state encodings,
// the iteration counter bus and the common register-width types.
package div_ctrl_pkg;

    typedef logic [31:0] RegBus;
    localparam RegBus ZeroWord = 32'h0000_0000;

    typedef logic [5:0] DivCntBus;

    localparam logic [1:0] DivOpDiv  = 2'b00;
    localparam logic [1:0] DivOpDivu = 2'b01;
    localparam logic [1:0] DivOpRem  = 2'b10;
    localparam logic [1:0] DivOpRemu = 2'b11;

    typedef enum logic [1:0] {
        DivIdle = 2'b00,
        DivBusy = 2'b01,
        DivDone = 2'b10
    } div_state_e;

    // DIV and REM treat their operands as two's complement
    function automatic logic div_op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder, DIV and DIVU the quotient
    function automatic logic div_op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration. The shifted partial remainder
// carries an extra bit so divisors with the MSB set compare correctly.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // shift in the next dividend bit, subtract when it fits
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        rem_o   = shifted[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], 1'b0};
        if (shifted >= {1'b0, divisor_i}) begin
            rem_o    = diff[XLEN-1:0];
            quo_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// RV32M divide sequencer: latches a request from ex, runs XLEN restoring
// iterations on operand magnitudes, applies sign fixup and holds the result
// until ex drops its request. Stalls the pipeline from the request cycle.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor skips the iterations
// and completes on the cycle after the request.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            annul_i,
    output logic            busy_o,
    output logic            stall_req_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    div_state_e state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             neg_quo_q;   // signed op with differing operand signs
    logic             neg_rem_q;   // signed op with negative dividend
    logic             zero_q;      // divisor was zero
    logic [XLEN-1:0]  dvd_q;       // original dividend, for divide-by-zero remainder
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;

    logic [XLEN-1:0]  step_rem, step_quo;
    logic             accept;
    logic             last_iter;
    logic             dvd_neg, dvs_neg;
    logic [XLEN-1:0]  quo_fix, rem_fix, res;

    assign accept    = (state == DivIdle) && start_i && !annul_i;
    assign last_iter = (cnt == CNT_W'(XLEN-1));
    assign dvd_neg   = div_op_signed(op_i) && dividend_i[XLEN-1];
    assign dvs_neg   = div_op_signed(op_i) && divisor_i[XLEN-1];

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= DivIdle;
        else     state <= state_nxt;
    end

    // next state: annul wins, DONE waits for ex to drop start
    always_comb begin
        state_nxt = state;
        if (annul_i) begin
            state_nxt = DivIdle;
        end else begin
            case (state)
                DivIdle: if (start_i) begin
`ifdef DIV_ZERO_FASTPATH_EN
                    state_nxt = (divisor_i == '0) ? DivDone : DivBusy;
`else
                    state_nxt = DivBusy;
`endif
                end
                DivBusy: if (last_iter) state_nxt = DivDone;
                DivDone: if (!start_i)  state_nxt = DivIdle;
                default: state_nxt = DivIdle;
            endcase
        end
    end

    // operand latch on accept, one iteration per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else if (accept) begin
            cnt       <= '0;
            op_q      <= op_i;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            zero_q    <= (divisor_i == '0);
            dvd_q     <= dividend_i;
            dvs_q     <= dvs_neg ? -divisor_i : divisor_i;
            quo_q     <= dvd_neg ? -dividend_i : dividend_i;
            rem_q     <= '0;
        end else if (state == DivBusy && !annul_i) begin
            cnt   <= cnt + 1'b1;
            rem_q <= step_rem;
            quo_q <= step_quo;
        end
    end

    // sign fixup; divide-by-zero bypasses it
    always_comb begin
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        if (zero_q) begin
            quo_fix = '1;
            rem_fix = dvd_q;
        end
        res = div_op_is_rem(op_q) ? rem_fix : quo_fix;
    end

    // outputs: stall covers the request cycle and all of BUSY
    always_comb begin
        busy_o      = (state == DivBusy);
        stall_req_o = !annul_i && !rst &&
                      ((state == DivBusy) || ((state == DivIdle) && start_i));
        ready_o     = (state == DivDone) && !annul_i;
        result_o    = ((state == DivDone) && !annul_i) ? res : '0;
    end

endmodule
